// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcodes, FSM states and instruction field positions for ctrl_unit_4bit
package ctrl_pkg;

    localparam logic [3:0] OP_NOP     = 4'b0000;
    localparam logic [3:0] OP_LDI     = 4'b0001;
    localparam logic [3:0] OP_JMP     = 4'b0010;
    localparam logic [3:0] OP_HALT    = 4'b0011;
    localparam logic [3:0] OP_ALU_MIN = 4'b0100;
    localparam logic [3:0] OP_ALU_MAX = 4'b1111;

    localparam int OP_MSB  = 11;
    localparam int OP_LSB  = 8;
    localparam int RD_MSB  = 7;
    localparam int RD_LSB  = 6;
    localparam int RS_MSB  = 5;
    localparam int RS_LSB  = 4;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
        S_WAIT,
        S_HALT
    } state_t;

endpackage

// File: rtl/ctrl_regfile.sv
// rtl/ctrl_regfile.sv - 4x4-bit register file, one write port, two operand reads and a debug read
module ctrl_regfile (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [1:0] waddr,
    input  logic [3:0] wdata,
    input  logic [1:0] raddr_a,
    input  logic [1:0] raddr_b,
    input  logic [1:0] dbg_sel,
    output logic [3:0] rdata_a,
    output logic [3:0] rdata_b,
    output logic [3:0] dbg_data
);

    logic [3:0][3:0] regs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a  = regs[raddr_a];
    assign rdata_b  = regs[raddr_b];
    assign dbg_data = regs[dbg_sel];

endmodule

// File: rtl/ctrl_unit_4bit.sv
// rtl/ctrl_unit_4bit.sv - microcore sequencer driving the ALU; CTRL_ACK_TIMEOUT_EN enables the ack timeout
module ctrl_unit_4bit
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [3:0]  pc,
    input  logic [11:0] instr,
    output logic        ula_en,
    output logic [3:0]  ula_a,
    output logic [3:0]  ula_b,
    output logic [3:0]  ula_sel,
    input  logic [3:0]  ula_result,
    input  logic        ula_ack,
    input  logic [1:0]  dbg_sel,
    output logic [3:0]  dbg_data,
    output logic        halted,
    output logic        err
);

    state_t      state, state_n;
    logic [11:0] ir, ir_n;
    logic [3:0]  pc_n;
    logic        ula_en_n;
    logic        load_ops;
    logic        rf_we;
    logic [3:0]  rf_wdata;
    logic [3:0]  op_a, op_b;
    logic        timeout;

    logic [3:0] op, imm;
    logic [1:0] rd, rs;
    assign op  = ir[OP_MSB:OP_LSB];
    assign rd  = ir[RD_MSB:RD_LSB];
    assign rs  = ir[RS_MSB:RS_LSB];
    assign imm = ir[IMM_MSB:IMM_LSB];

    ctrl_regfile u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (rf_we),
        .waddr    (rd),
        .wdata    (rf_wdata),
        .raddr_a  (rd),
        .raddr_b  (rs),
        .dbg_sel  (dbg_sel),
        .rdata_a  (op_a),
        .rdata_b  (op_b),
        .dbg_data (dbg_data)
    );

    always_comb begin
        state_n  = state;
        ir_n     = ir;
        pc_n     = pc;
        ula_en_n = 1'b0;
        load_ops = 1'b0;
        rf_we    = 1'b0;
        rf_wdata = ula_result;
        case (state)
            S_FETCH: begin
                ir_n    = instr;
                pc_n    = pc + 4'd1;
                state_n = S_DECODE;
            end
            S_DECODE: begin
                state_n = S_FETCH;
                case (op)
                    OP_NOP: ;
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = imm;
                    end
                    OP_JMP:  pc_n = imm;
                    OP_HALT: state_n = S_HALT;
                    default: begin
                        load_ops = 1'b1;
                        ula_en_n = 1'b1;
                        state_n  = S_WAIT;
                    end
                endcase
            end
            S_WAIT: begin
                if (ula_ack) begin
                    rf_we   = 1'b1;
                    state_n = S_FETCH;
                end else if (timeout) begin
                    state_n = S_HALT;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            ir      <= '0;
            pc      <= '0;
            ula_en  <= 1'b0;
            ula_a   <= '0;
            ula_b   <= '0;
            ula_sel <= '0;
        end else begin
            state  <= state_n;
            ir     <= ir_n;
            pc     <= pc_n;
            ula_en <= ula_en_n;
            // Operands stay frozen through WAIT so the ALU can sample them late
            if (load_ops) begin
                ula_a   <= op_a;
                ula_b   <= op_b;
                ula_sel <= op;
            end
        end
    end

    assign halted = (state == S_HALT);

`ifdef CTRL_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    assign timeout = (state == S_WAIT) && !ula_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (state != S_WAIT) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_unit_4bit.sv
// tb/tb_ctrl_unit_4bit.sv - self-checking bench for ctrl_unit_4bit with ROM, responder ALU and reference model
module tb_ctrl_unit_4bit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  pc;
    logic [11:0] instr;
    logic        ula_en;
    logic [3:0]  ula_a, ula_b, ula_sel;
    logic [3:0]  ula_result;
    logic        ula_ack;
    logic [1:0]  dbg_sel = 2'd0;
    logic [3:0]  dbg_data;
    logic        halted, err;

    logic [11:0] rom [16];
    logic        alu_mute = 1'b0;
    logic        alu_ack = 1'b0;
    logic [3:0]  alu_result = 4'd0;
    logic        stray_ack = 1'b0;
    logic [3:0]  stray_result = 4'd0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    assign instr      = rom[pc];
    assign ula_ack    = alu_ack | stray_ack;
    assign ula_result = stray_ack ? stray_result : alu_result;

    ctrl_unit_4bit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .instr      (instr),
        .ula_en     (ula_en),
        .ula_a      (ula_a),
        .ula_b      (ula_b),
        .ula_sel    (ula_sel),
        .ula_result (ula_result),
        .ula_ack    (ula_ack),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data),
        .halted     (halted),
        .err        (err)
    );

    function automatic logic [3:0] alu_f(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int s;
        if (sel >= 4'b1100) begin
            s = (int'(a) - int'(b) + 16) % 16;
            return 4'(s);
        end
        if (sel >= 4'b1000) begin
            s = (int'(a) + int'(b)) % 16;
            return 4'(s);
        end
        case (sel)
            4'b0100: return a | b;
            4'b0101: return a & b;
            4'b0110: return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    // Standard ALU: samples the enable on one edge, answers with ack/result for one cycle
    always @(posedge clk) begin
        alu_ack    <= ula_en & ~alu_mute;
        alu_result <= alu_f(ula_sel, ula_a, ula_b);
    end

    function automatic logic [11:0] mk(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [3:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 12'h000;
    endtask

    task automatic start();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) rom[i] = 12'($urandom);
        rst_n = 1'b0;
        #2;
        tick(2);
        checks++; if (pc !== 4'd0) begin fails++; $display("FAIL reset_pc got %0d want 0", pc); end
        checks++; if (ula_en !== 1'b0) begin fails++; $display("FAIL reset_ula_en got %b want 0", ula_en); end
        checks++; if ({ula_a, ula_b, ula_sel} !== 12'h000) begin fails++; $display("FAIL reset_operands got %h want 000", {ula_a, ula_b, ula_sel}); end
        checks++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", err); end
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++; if (dbg_data !== 4'd0) begin fails++; $display("FAIL reset_R%0d got %0d want 0", r, dbg_data); end
        end
    endtask

    task automatic test_ldi();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd1, 2'd0, 4'd5);
        start();
        tick(1);
        checks++; if (pc !== 4'd1) begin fails++; $display("FAIL ldi_pc_edge1 got %0d want 1", pc); end
        tick(1);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 4'd5) begin fails++; $display("FAIL ldi_R1 got %0d want 5", dbg_data); end
        checks++; if (pc !== 4'd1) begin fails++; $display("FAIL ldi_pc got %0d want 1", pc); end
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd0) begin fails++; $display("FAIL ldi_R0 got %0d want 0", dbg_data); end
    endtask

    task automatic test_add();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd0, 2'd0, 4'd3);
        rom[1] = mk(4'b0001, 2'd1, 2'd0, 4'd5);
        rom[2] = mk(4'b1000, 2'd0, 2'd1, 4'd0);
        rom[3] = mk(4'b0001, 2'd2, 2'd0, 4'd9);
        rom[4] = mk(4'b0001, 2'd3, 2'd0, 4'd9);
        rom[5] = mk(4'b1011, 2'd2, 2'd3, 4'd0);
        rom[6] = mk(4'b1001, 2'd1, 2'd1, 4'd0);
        start();
        tick(5);
        checks++; if (ula_en !== 1'b0) begin fails++; $display("FAIL add_en_edge1 got %b want 0", ula_en); end
        tick(1);
        checks++; if (ula_en !== 1'b1) begin fails++; $display("FAIL add_en_edge2 got %b want 1", ula_en); end
        checks++; if ({ula_a, ula_b, ula_sel} !== {4'd3, 4'd5, 4'b1000}) begin fails++; $display("FAIL add_operands got %h want 358", {ula_a, ula_b, ula_sel}); end
        tick(1);
        checks++; if (ula_en !== 1'b0) begin fails++; $display("FAIL add_en_edge3 got %b want 0", ula_en); end
        checks++; if ({ula_a, ula_b, ula_sel} !== {4'd3, 4'd5, 4'b1000}) begin fails++; $display("FAIL add_hold got %h want 358", {ula_a, ula_b, ula_sel}); end
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd3) begin fails++; $display("FAIL add_R0_early got %0d want 3", dbg_data); end
        tick(1);
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd8) begin fails++; $display("FAIL add_R0 got %0d want 8", dbg_data); end
        checks++; if (pc !== 4'd3) begin fails++; $display("FAIL add_pc got %0d want 3", pc); end
        tick(8);
        dbg_sel = 2'd2; #1;
        checks++; if (dbg_data !== 4'd2) begin fails++; $display("FAIL add_wrap_R2 got %0d want 2", dbg_data); end
        tick(4);
        dbg_sel = 2'd1; #1;
        checks++; if (dbg_data !== 4'd10) begin fails++; $display("FAIL add_same_reg_R1 got %0d want 10", dbg_data); end
    endtask

    task automatic test_alu_ops();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd0, 2'd0, 4'd3);
        rom[1] = mk(4'b0001, 2'd1, 2'd0, 4'd5);
        rom[2] = mk(4'b1100, 2'd0, 2'd1, 4'd0);
        rom[3] = mk(4'b0001, 2'd2, 2'd0, 4'b1100);
        rom[4] = mk(4'b0001, 2'd3, 2'd0, 4'b1010);
        rom[5] = mk(4'b0100, 2'd2, 2'd3, 4'd0);
        rom[6] = mk(4'b0001, 2'd2, 2'd0, 4'b1100);
        rom[7] = mk(4'b0111, 2'd2, 2'd3, 4'd0);
        start();
        tick(8);
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd14) begin fails++; $display("FAIL sub_R0 got %0d want 14", dbg_data); end
        tick(8);
        dbg_sel = 2'd2; #1;
        checks++; if (dbg_data !== 4'b1110) begin fails++; $display("FAIL op0100_R2 got %b want 1110", dbg_data); end
        tick(6);
        dbg_sel = 2'd2; #1;
        checks++; if (dbg_data !== 4'b0111) begin fails++; $display("FAIL op0111_R2 got %b want 0111", dbg_data); end
    endtask

    task automatic test_jmp_halt();
        clear_rom();
        rom[0]  = mk(4'b0010, 2'd0, 2'd0, 4'd15);
        rom[15] = mk(4'b0000, 2'd0, 2'd0, 4'd0);
        start();
        tick(2);
        checks++; if (pc !== 4'd15) begin fails++; $display("FAIL jmp_pc got %0d want 15", pc); end
        tick(1);
        checks++; if (pc !== 4'd0) begin fails++; $display("FAIL wrap_pc got %0d want 0", pc); end
        rom[0] = mk(4'b0011, 2'd0, 2'd0, 4'd0);
        tick(3);
        checks++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag got %b want 1", halted); end
        tick(10);
        checks++; if (pc !== 4'd1) begin fails++; $display("FAIL halt_pc_frozen got %0d want 1", pc); end
        checks++; if (halted !== 1'b1 || ula_en !== 1'b0) begin fails++; $display("FAIL halt_hold got halted=%b en=%b want 1/0", halted, ula_en); end
    endtask

    task automatic test_stray_ack();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd0, 2'd0, 4'd6);
        start();
        stray_result = 4'd9;
        stray_ack = 1'b1;
        tick(8);
        stray_ack = 1'b0;
        for (int r = 0; r < 4; r++) begin
            dbg_sel = 2'(r); #1;
            checks++;
            if (dbg_data !== ((r == 0) ? 4'd6 : 4'd0)) begin
                fails++; $display("FAIL stray_ack_R%0d got %0d want %0d", r, dbg_data, (r == 0) ? 6 : 0);
            end
        end
    endtask

    task automatic test_wait();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd0, 2'd0, 4'd3);
        rom[1] = mk(4'b0001, 2'd1, 2'd0, 4'd5);
        rom[2] = mk(4'b1000, 2'd0, 2'd1, 4'd0);
        alu_mute = 1'b1;
        start();
        tick(6);
`ifdef CTRL_ACK_TIMEOUT_EN
        tick(3);
        checks++; if (err !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL timeout_early got err=%b halted=%b want 0/0", err, halted); end
        tick(1);
        checks++; if (err !== 1'b1 || halted !== 1'b1) begin fails++; $display("FAIL timeout got err=%b halted=%b want 1/1", err, halted); end
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd3) begin fails++; $display("FAIL timeout_R0 got %0d want 3", dbg_data); end
        tick(5);
        checks++; if (pc !== 4'd3 || err !== 1'b1) begin fails++; $display("FAIL timeout_sticky got pc=%0d err=%b want 3/1", pc, err); end
`else
        tick(10);
        checks++; if (err !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL wait_flags got err=%b halted=%b want 0/0", err, halted); end
        checks++; if (ula_en !== 1'b0 || ula_a !== 4'd3 || ula_sel !== 4'b1000) begin fails++; $display("FAIL wait_hold got en=%b a=%0d sel=%b", ula_en, ula_a, ula_sel); end
        stray_result = 4'd11;
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd11) begin fails++; $display("FAIL late_ack_R0 got %0d want 11", dbg_data); end
`endif
        alu_mute = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        clear_rom();
        rom[0] = mk(4'b0001, 2'd0, 2'd0, 4'd3);
        rom[1] = mk(4'b0001, 2'd1, 2'd0, 4'd5);
        rom[2] = mk(4'b1000, 2'd0, 2'd1, 4'd0);
        alu_mute = 1'b1;
        start();
        tick(7);
        rst_n = 1'b0;
        #1;
        checks++; if (pc !== 4'd0 || ula_en !== 1'b0 || halted !== 1'b0 || err !== 1'b0) begin
            fails++; $display("FAIL midwait_reset got pc=%0d en=%b halted=%b err=%b want 0", pc, ula_en, halted, err);
        end
        checks++; if ({ula_a, ula_b, ula_sel} !== 12'h000) begin fails++; $display("FAIL midwait_operands got %h want 000", {ula_a, ula_b, ula_sel}); end
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd0) begin fails++; $display("FAIL midwait_R0 got %0d want 0", dbg_data); end
        tick(1);
        rst_n = 1'b1;
        alu_mute = 1'b0;
        stray_result = 4'd13;
        stray_ack = 1'b1;
        tick(1);
        stray_ack = 1'b0;
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd0 || pc !== 4'd1) begin fails++; $display("FAIL late_ack_ignored got R0=%0d pc=%0d want 0/1", dbg_data, pc); end
        tick(1);
        dbg_sel = 2'd0; #1;
        checks++; if (dbg_data !== 4'd3) begin fails++; $display("FAIL restart_R0 got %0d want 3", dbg_data); end
    endtask

    task automatic test_random();
        logic [3:0] mreg [4];
        logic [3:0] mpc;
        logic [11:0] ins;
        logic [3:0] op;
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 16; i++) begin
                op = 4'($urandom_range(0, 15));
                if (op == 4'b0011) op = 4'b0001;
                rom[i] = mk(op, 2'($urandom), 2'($urandom), 4'($urandom));
            end
            for (int r = 0; r < 4; r++) mreg[r] = 4'd0;
            mpc = 4'd0;
            start();
            for (int k = 0; k < 30; k++) begin
                ins = rom[mpc];
                op = ins[11:8];
                mpc = mpc + 4'd1;
                if (op == 4'b0001) mreg[ins[7:6]] = ins[3:0];
                else if (op == 4'b0010) mpc = ins[3:0];
                else if (op >= 4'b0100) mreg[ins[7:6]] = alu_f(op, mreg[ins[7:6]], mreg[ins[5:4]]);
                tick((op >= 4'b0100) ? 4 : 2);
                checks++; if (pc !== mpc) begin fails++; $display("FAIL rand_pc r%0d k%0d got %0d want %0d", round, k, pc, mpc); end
                for (int r = 0; r < 4; r++) begin
                    dbg_sel = 2'(r); #1;
                    checks++;
                    if (dbg_data !== mreg[r]) begin
                        fails++; $display("FAIL rand_R%0d r%0d k%0d got %0d want %0d", r, round, k, dbg_data, mreg[r]);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_ldi();
        test_add();
        test_alu_ops();
        test_jmp_halt();
        test_stray_ack();
        test_wait();
        test_reset_mid_wait();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_unit_4bit.md
# ctrl_unit_4bit

Sequencer for the 4-bit microcore, sitting directly upstream of the synchronous ALU. It fetches 12-bit instructions from a program ROM and decodes them. Non-ALU instructions execute locally. ALU instructions issue one-cycle `ula_en` pulses with operands and selector, wait for `ula_ack`, and write the ALU result back into a 4×4-bit register file.

## Interface
- `TIMEOUT`, default 4: cycles spent in WAIT without `ula_ack` before error. Used only with the macro.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc` out 4: ROM address, registered.
- `instr` in 12: ROM data for `pc`, combinational. Fields: `op[11:8]`, `rd[7:6]`, `rs[5:4]`, `imm[3:0]`.
- `ula_en` out 1: ALU enable, registered one-cycle pulse.
- `ula_a`, `ula_b` out 4: ALU operands, registered.
- `ula_sel` out 4: ALU selector, registered; equals `op`.
- `ula_result` in 4: ALU result.
- `ula_ack` in 1: ALU completion, high one cycle.
- `dbg_sel` in 2: register-file read index.
- `dbg_data` out 4: `R[dbg_sel]`, combinational.
- `halted` out 1: high in HALT.
- `err` out 1: sticky ack-timeout flag.

## Operation
- Reset values: state FETCH; `pc`, `ula_a`, `ula_b`, `ula_sel` = 0; `ula_en`, `halted`, `err` = 0; R0–R3 = 0; IR = 0.
- Opcodes:
  - 0000 NOP.
  - 0001 LDI: `R[rd] <= imm`.
  - 0010 JMP: `pc <= imm`.
  - 0011 HALT.
  - 0100–1111 ALU: `a = R[rd]`, `b = R[rs]`, `sel = op`, `R[rd] <= result`.
  - 10xx is add and 11xx is subtract, both mod 16.
- FETCH:
  - IR <= `instr`.
  - `pc <= pc + 1` mod 16; 15 wraps to 0.
  - Next state: DECODE.
- DECODE:
  - NOP/LDI/JMP: execute, then FETCH.
  - JMP overrides the FETCH increment.
  - HALT: go to HALT; `halted` = 1.
  - ALU: latch `ula_a`/`ula_b`/`ula_sel`, set `ula_en` = 1, go to WAIT.
- WAIT:
  - `ula_en` <= 0 on the first WAIT edge, so exactly a one-cycle pulse.
  - On a sampled `ula_ack` = 1: `R[rd] <= ula_result`, go to FETCH.
  - Operand and selector outputs hold their values throughout WAIT.
- HALT: terminal; only `rst_n` exits. `pc` frozen, `ula_en` = 0.
- `rd == rs`: legal; both operands are the same register.
- `ula_ack` outside WAIT: ignored, no register write.
- Reset asserted mid-WAIT: all state returns to reset values immediately; a late `ula_ack` after release is ignored.

## Timing
- Edge numbering:
  - Edge 1: FETCH → DECODE.
  - Edge 2: DECODE → WAIT; `ula_en` rises.
  - Edge 3: ALU samples the enable and raises ack/result.
  - Edge 4: WAIT samples ack, writes `R[rd]`, goes to FETCH.
- ALU instruction: 4 cycles against the standard ALU.
- NOP/LDI/JMP: 2 cycles each.
- `dbg_data` reflects a write on the cycle after the writing edge.

## Configuration
- `CTRL_ACK_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - After `TIMEOUT` consecutive WAIT cycles without ack: `err` = 1, `halted` = 1, state HALT, no register write.
  - Counter clears on entry to WAIT.
- Not defined: WAIT lasts indefinitely, `err` is tied 0, and no counter is built.

## Structure
- Package `ctrl_pkg`:
  - Opcode constants: NOP, LDI, JMP, HALT, ALU range.
  - State enum: FETCH, DECODE, WAIT, HALT.
  - Instruction field positions.
- Sub-module `ctrl_regfile`:
  - 4×4 registers, one synchronous write port.
  - Two combinational read ports for operands, plus the debug read port.
  - Async active-low reset.

## Test plan
- Reset, then `LDI R1,5` → 2 cycles later `dbg_data`(sel=1) = 5, `pc` = 1.
- R0=3, R1=5, op 1000 (add) rd=0 rs=1 → `ula_en` pulses one cycle with a=3, b=5, sel=1000; R0 = 8 at edge 4; 9+9 gives 2 (wrap).
- R0=3, R1=5, op 1100 (subtract) rd=0 rs=1 → R0 = 14.
- Logic ops: R0=1100, R1=1010, op 0100 → 1110; op 0111 → 0111.
- JMP 15, then a NOP at address 15 → `pc` sequence 15 then 0 (wrap); `HALT` → `halted` = 1, `pc` frozen for 10 cycles.
- Fake ALU with ack held low, macro on → `err` = 1 after 4 WAIT cycles, R0 unchanged. Second run: `rst_n` low during WAIT → all outputs return to reset values, and a late ack is ignored.
